// File: rtl/memory_stage.sv
// Memory pipeline stage: EX/MEM stage register, single-outstanding data-memory req/ack bus and
// the writeback register. Optional forwarding outputs are enabled by MEMORY_STAGE_FWD_EN.
module memory_stage #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RF_ADDR_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  input  logic                 rf_we_i,
  input  logic                 mem_we_i,
  input  logic                 mem2rf_i,
  input  logic [XLEN-1:0]      mem_wdata_i,
  input  logic [RF_ADDR_W-1:0] rf_waddr_i,
  input  logic [XLEN-1:0]      alu_result_i,
  output logic                 stall_o,
  output logic                 dmem_req_o,
  output logic                 dmem_we_o,
  output logic [XLEN-1:0]      dmem_addr_o,
  output logic [XLEN-1:0]      dmem_wdata_o,
  input  logic                 dmem_ack_i,
  input  logic [XLEN-1:0]      dmem_rdata_i,
`ifdef MEMORY_STAGE_FWD_EN
  output logic                 fwd_valid_o,
  output logic [RF_ADDR_W-1:0] fwd_waddr_o,
  output logic [XLEN-1:0]      fwd_data_o,
`endif
  output logic                 valid_o,
  output logic                 rf_we_o,
  output logic [RF_ADDR_W-1:0] rf_waddr_o,
  output logic [XLEN-1:0]      rf_wdata_o
);

  typedef enum logic {StIdle, StReq} state_e;

  state_e state, state_next;

  logic                 s_valid;
  logic                 s_rf_we;
  logic                 s_mem_we;
  logic                 s_mem2rf;
  logic [XLEN-1:0]      s_mem_wdata;
  logic [RF_ADDR_W-1:0] s_rf_waddr;
  logic [XLEN-1:0]      s_alu_result;

  logic is_mem;
  logic in_is_mem;
  logic capture;
  logic acked;

  assign is_mem    = s_valid & (s_mem_we | s_mem2rf);
  assign in_is_mem = valid_i & (mem_we_i | mem2rf_i);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= StIdle;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state: REQ persists across an ack edge that captures another memory op
  always_comb begin
    state_next = state;
    unique case (state)
      StIdle: if (in_is_mem) state_next = StReq;
      StReq:  if (dmem_ack_i && !in_is_mem) state_next = StIdle;
      default: state_next = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    dmem_req_o = (state == StReq);
    stall_o    = dmem_req_o & ~dmem_ack_i;
    acked      = dmem_req_o & dmem_ack_i;
    capture    = ~stall_o;
  end

  assign dmem_we_o    = s_mem_we;
  assign dmem_addr_o  = s_alu_result;
  assign dmem_wdata_o = s_mem_wdata;

  // EX/MEM stage register
  always_ff @(posedge clk) begin
    if (rst) begin
      s_valid      <= 1'b0;
      s_rf_we      <= 1'b0;
      s_mem_we     <= 1'b0;
      s_mem2rf     <= 1'b0;
      s_mem_wdata  <= '0;
      s_rf_waddr   <= '0;
      s_alu_result <= '0;
    end else if (capture) begin
      s_valid      <= valid_i;
      s_rf_we      <= rf_we_i;
      s_mem_we     <= mem_we_i;
      s_mem2rf     <= mem2rf_i;
      s_mem_wdata  <= mem_wdata_i;
      s_rf_waddr   <= rf_waddr_i;
      s_alu_result <= alu_result_i;
    end
  end

  // Writeback register: RF fields hold their last value when nothing completes
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o    <= 1'b0;
      rf_we_o    <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
    end else if (s_valid && !is_mem) begin
      valid_o    <= 1'b1;
      rf_we_o    <= s_rf_we;
      rf_waddr_o <= s_rf_waddr;
      rf_wdata_o <= s_alu_result;
    end else if (acked) begin
      valid_o    <= 1'b1;
      rf_we_o    <= s_rf_we;
      rf_waddr_o <= s_rf_waddr;
      rf_wdata_o <= s_mem2rf ? dmem_rdata_i : s_alu_result;
    end else begin
      valid_o    <= 1'b0;
    end
  end

`ifdef MEMORY_STAGE_FWD_EN
  assign fwd_valid_o = s_valid & s_rf_we & ~s_mem2rf;
  assign fwd_waddr_o = s_rf_waddr;
  assign fwd_data_o  = s_alu_result;
`endif

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed scenarios plus a randomized run checked
// against a transaction-level model (in-order writeback and access queues).
module tb_memory_stage;

  localparam int XLEN = 32;
  localparam int AW   = 32;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] waddr;
    logic [XLEN-1:0] wdata;
  } wb_t;

  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } acc_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            valid_i, rf_we_i, mem_we_i, mem2rf_i;
  logic [XLEN-1:0] mem_wdata_i, alu_result_i, dmem_rdata_i;
  logic [AW-1:0]   rf_waddr_i;
  logic            dmem_ack_i;
  logic            stall_o, dmem_req_o, dmem_we_o;
  logic [XLEN-1:0] dmem_addr_o, dmem_wdata_o;
  logic            valid_o, rf_we_o;
  logic [AW-1:0]   rf_waddr_o;
  logic [XLEN-1:0] rf_wdata_o;
`ifdef MEMORY_STAGE_FWD_EN
  logic            fwd_valid_o;
  logic [AW-1:0]   fwd_waddr_o;
  logic [XLEN-1:0] fwd_data_o;
`endif

  int errors = 0;
  int checks = 0;

  memory_stage #(.XLEN(XLEN), .RF_ADDR_W(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .rf_we_i      (rf_we_i),
    .mem_we_i     (mem_we_i),
    .mem2rf_i     (mem2rf_i),
    .mem_wdata_i  (mem_wdata_i),
    .rf_waddr_i   (rf_waddr_i),
    .alu_result_i (alu_result_i),
    .stall_o      (stall_o),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_ack_i   (dmem_ack_i),
    .dmem_rdata_i (dmem_rdata_i),
`ifdef MEMORY_STAGE_FWD_EN
    .fwd_valid_o  (fwd_valid_o),
    .fwd_waddr_o  (fwd_waddr_o),
    .fwd_data_o   (fwd_data_o),
`endif
    .valid_o      (valid_o),
    .rf_we_o      (rf_we_o),
    .rf_waddr_o   (rf_waddr_o),
    .rf_wdata_o   (rf_wdata_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic mwe, input logic m2r,
                       input logic [XLEN-1:0] wd, input logic [AW-1:0] wa,
                       input logic [XLEN-1:0] alu);
    valid_i = v; rf_we_i = we; mem_we_i = mwe; mem2rf_i = m2r;
    mem_wdata_i = wd; rf_waddr_i = wa; alu_result_i = alu;
  endtask

  // Data returned by the bench's memory for a given address
  function automatic logic [XLEN-1:0] mem_fn(input logic [XLEN-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    dmem_ack_i = 1'b0; dmem_rdata_i = '0;
    step(); step();
    checks++;
    if ({valid_o, rf_we_o, dmem_req_o, stall_o} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got valid/we/req/stall=%b expected 0000",
               {valid_o, rf_we_o, dmem_req_o, stall_o});
    end
    checks++;
    if ({rf_waddr_o, rf_wdata_o} !== '0) begin
      errors++;
      $display("FAIL reset_data: got waddr=%h wdata=%h expected 0", rf_waddr_o, rf_wdata_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_alu_op();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'd5, 32'h1234);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    checks++;
    if (valid_o !== 1'b0 || dmem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL alu_edge1: got valid=%b req=%b expected 0 0", valid_o, dmem_req_o);
    end
    step();
    checks++;
    if ({valid_o, rf_we_o, rf_waddr_o, rf_wdata_o, dmem_req_o} !==
        {1'b1, 1'b1, 32'd5, 32'h1234, 1'b0}) begin
      errors++;
      $display("FAIL alu_wb: got valid=%b we=%b waddr=%0d wdata=%h req=%b expected 1 1 5 1234 0",
               valid_o, rf_we_o, rf_waddr_o, rf_wdata_o, dmem_req_o);
    end
    step();
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("FAIL alu_pulse: got valid=%b expected 0", valid_o);
    end
  endtask

  task automatic test_load_wait();
    int stalls = 0;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 32'd9, 32'h100);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      dmem_ack_i = (i == 3);
      dmem_rdata_i = (i == 3) ? 32'hDEAD_BEEF : 32'h1111_1111;
      #1;
      checks++;
      if ({dmem_req_o, dmem_we_o, dmem_addr_o} !== {1'b1, 1'b0, 32'h100}) begin
        errors++;
        $display("FAIL load_bus[%0d]: got req=%b we=%b addr=%h expected 1 0 100",
                 i, dmem_req_o, dmem_we_o, dmem_addr_o);
      end
      if (stall_o) stalls++;
      step();
    end
    dmem_ack_i = 1'b0;
    #1;
    checks++;
    if (stalls != 3) begin
      errors++;
      $display("FAIL load_stalls: got %0d stall cycles expected 3", stalls);
    end
    checks++;
    if ({valid_o, rf_waddr_o, rf_wdata_o, dmem_req_o} !== {1'b1, 32'd9, 32'hDEAD_BEEF, 1'b0}) begin
      errors++;
      $display("FAIL load_wb: got valid=%b waddr=%0d wdata=%h req=%b expected 1 9 deadbeef 0",
               valid_o, rf_waddr_o, rf_wdata_o, dmem_req_o);
    end
  endtask

  task automatic test_store_zero_wait();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'hA5A5_A5A5, 32'd3, 32'h200);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    dmem_ack_i = 1'b1;
    #1;
    checks++;
    if ({dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, stall_o} !==
        {1'b1, 1'b1, 32'h200, 32'hA5A5_A5A5, 1'b0}) begin
      errors++;
      $display("FAIL store_bus: got req=%b we=%b addr=%h wdata=%h stall=%b expected 1 1 200 a5a5a5a5 0",
               dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, stall_o);
    end
    step();
    dmem_ack_i = 1'b0;
    #1;
    checks++;
    if ({dmem_req_o, valid_o, rf_we_o, rf_wdata_o} !== {1'b0, 1'b1, 1'b0, 32'h200}) begin
      errors++;
      $display("FAIL store_wb: got req=%b valid=%b we=%b wdata=%h expected 0 1 0 200",
               dmem_req_o, valid_o, rf_we_o, rf_wdata_o);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b1, 1'b0, 1'b1, '0, 32'd1, 32'h10);
    step();
    drive(1'b1, 1'b1, 1'b0, 1'b1, '0, 32'd2, 32'h14);
    dmem_ack_i = 1'b0;
    #1;
    checks++;
    if ({dmem_req_o, dmem_addr_o, stall_o} !== {1'b1, 32'h10, 1'b1}) begin
      errors++;
      $display("FAIL b2b_wait1: got req=%b addr=%h stall=%b expected 1 10 1",
               dmem_req_o, dmem_addr_o, stall_o);
    end
    step();
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'h0BAD_F00D;
    #1;
    checks++;
    if ({dmem_req_o, dmem_addr_o, stall_o} !== {1'b1, 32'h10, 1'b0}) begin
      errors++;
      $display("FAIL b2b_ack1: got req=%b addr=%h stall=%b expected 1 10 0",
               dmem_req_o, dmem_addr_o, stall_o);
    end
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    dmem_ack_i = 1'b0;
    #1;
    checks++;
    if ({dmem_req_o, dmem_addr_o, valid_o, rf_waddr_o, rf_wdata_o} !==
        {1'b1, 32'h14, 1'b1, 32'd1, 32'h0BAD_F00D}) begin
      errors++;
      $display("FAIL b2b_switch: got req=%b addr=%h valid=%b waddr=%0d wdata=%h expected 1 14 1 1 0badf00d",
               dmem_req_o, dmem_addr_o, valid_o, rf_waddr_o, rf_wdata_o);
    end
    step();
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'h1357_9BDF;
    #1;
    checks++;
    if ({dmem_req_o, dmem_addr_o, valid_o} !== {1'b1, 32'h14, 1'b0}) begin
      errors++;
      $display("FAIL b2b_ack2: got req=%b addr=%h valid=%b expected 1 14 0",
               dmem_req_o, dmem_addr_o, valid_o);
    end
    step();
    dmem_ack_i = 1'b0;
    #1;
    checks++;
    if ({dmem_req_o, valid_o, rf_waddr_o, rf_wdata_o} !== {1'b0, 1'b1, 32'd2, 32'h1357_9BDF}) begin
      errors++;
      $display("FAIL b2b_wb2: got req=%b valid=%b waddr=%0d wdata=%h expected 0 1 2 13579bdf",
               dmem_req_o, valid_o, rf_waddr_o, rf_wdata_o);
    end
    step();
  endtask

  task automatic test_reset_mid_access();
    drive(1'b1, 1'b1, 1'b0, 1'b1, '0, 32'd4, 32'h300);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    dmem_ack_i = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++;
    if ({dmem_req_o, valid_o, stall_o} !== 3'b000) begin
      errors++;
      $display("FAIL rst_mid: got req=%b valid=%b stall=%b expected 000",
               dmem_req_o, valid_o, stall_o);
    end
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'hFFFF_0000;
    step();
    dmem_ack_i = 1'b0;
    #1;
    checks++;
    if ({dmem_req_o, valid_o, stall_o} !== 3'b000) begin
      errors++;
      $display("FAIL late_ack: got req=%b valid=%b stall=%b expected 000",
               dmem_req_o, valid_o, stall_o);
    end
  endtask

`ifdef MEMORY_STAGE_FWD_EN
  task automatic test_forwarding();
    drive(1'b1, 1'b1, 1'b0, 1'b0, '0, 32'd7, 32'h55);
    step();
    drive(1'b1, 1'b1, 1'b0, 1'b1, '0, 32'd8, 32'h400);
    #1;
    checks++;
    if ({fwd_valid_o, fwd_waddr_o, fwd_data_o} !== {1'b1, 32'd7, 32'h55}) begin
      errors++;
      $display("FAIL fwd_alu: got valid=%b waddr=%0d data=%h expected 1 7 55",
               fwd_valid_o, fwd_waddr_o, fwd_data_o);
    end
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    #1;
    checks++;
    if (fwd_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL fwd_load: got valid=%b expected 0", fwd_valid_o);
    end
    dmem_ack_i = 1'b1;
    step();
    dmem_ack_i = 1'b0;
    step();
  endtask
`endif

  task automatic test_random();
    wb_t  wbq[$];
    acc_t accq[$];
    wb_t  wb_exp;
    acc_t acc_exp;
    bit   have = 0;
    int   wait_cnt = -1;
    int   issued = 0;
    int   retired = 0;
    int   kind;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (!have) begin
        kind = $urandom_range(0, 3);
        drive((cyc < 1800) && ($urandom_range(0, 3) != 0), 1'($urandom), kind[0] & kind[1] | kind == 2,
              kind[0], $urandom, $urandom, $urandom);
        have = 1;
      end
      if (dmem_req_o && wait_cnt < 0) wait_cnt = $urandom_range(0, 3);
      // Acks while idle are random noise the stage must ignore
      dmem_ack_i = dmem_req_o ? (wait_cnt == 0) : 1'($urandom_range(0, 1));
      dmem_rdata_i = dmem_ack_i ? mem_fn(dmem_addr_o) : $urandom;
      #1;
      if (dmem_req_o && dmem_ack_i) begin
        checks++;
        if (accq.size() == 0) begin
          errors++;
          $display("FAIL rand_access: unexpected access addr=%h", dmem_addr_o);
        end else begin
          acc_exp = accq.pop_front();
          if ({dmem_we_o, dmem_addr_o, dmem_wdata_o} !== acc_exp) begin
            errors++;
            $display("FAIL rand_access: got we=%b addr=%h wdata=%h expected we=%b addr=%h wdata=%h",
                     dmem_we_o, dmem_addr_o, dmem_wdata_o, acc_exp.we, acc_exp.addr, acc_exp.wdata);
          end
        end
        wait_cnt = -1;
      end else if (dmem_req_o) begin
        wait_cnt--;
      end
      if (valid_o) begin
        retired++;
        checks++;
        if (wbq.size() == 0) begin
          errors++;
          $display("FAIL rand_wb: unexpected writeback waddr=%h", rf_waddr_o);
        end else begin
          wb_exp = wbq.pop_front();
          if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== wb_exp) begin
            errors++;
            $display("FAIL rand_wb: got we=%b waddr=%h wdata=%h expected we=%b waddr=%h wdata=%h",
                     rf_we_o, rf_waddr_o, rf_wdata_o, wb_exp.we, wb_exp.waddr, wb_exp.wdata);
          end
        end
      end
      if (!stall_o) begin
        if (valid_i) begin
          issued++;
          wbq.push_back('{we: rf_we_i, waddr: rf_waddr_i,
                          wdata: mem2rf_i ? mem_fn(alu_result_i) : alu_result_i});
          if (mem_we_i || mem2rf_i)
            accq.push_back('{we: mem_we_i, addr: alu_result_i, wdata: mem_wdata_i});
        end
        have = 0;
      end
      step();
    end
    dmem_ack_i = 1'b0;
    checks++;
    if (wbq.size() != 0 || accq.size() != 0 || retired != issued || issued == 0) begin
      errors++;
      $display("FAIL rand_drain: got issued=%0d retired=%0d pending_wb=%0d pending_acc=%0d",
               issued, retired, wbq.size(), accq.size());
    end
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_load_wait();
    test_store_zero_wait();
    test_back_to_back();
    test_reset_mid_access();
`ifdef MEMORY_STAGE_FWD_EN
    test_forwarding();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Registers execute results into the EX/MEM stage register and performs data-memory loads and stores over a single-outstanding req/ack bus.
- Stalls upstream while an access is pending.
- Presents registered results (ALU value or load data) to the writeback stage.

Parameters:
- XLEN, 32, datapath and memory address/data width
- RF_ADDR_W, 32, width of the register-file write-address field carried down the pipe

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous reset, active-high
- valid_i  input  1  execute output holds a real instruction
- rf_we_i  input  1  instruction writes the register file
- mem_we_i  input  1  instruction is a store
- mem2rf_i  input  1  instruction is a load (RF data comes from memory)
- mem_wdata_i  input  XLEN  store data
- rf_waddr_i  input  RF_ADDR_W  RF destination
- alu_result_i  input  XLEN  ALU result; memory address for loads/stores
- stall_o  output  1  upstream must hold its outputs; this stage does not capture
- dmem_req_o  output  1  memory request valid
- dmem_we_o  output  1  1 = store, 0 = load
- dmem_addr_o  output  XLEN  access address
- dmem_wdata_o  output  XLEN  store data
- dmem_ack_i  input  1  memory accepts/completes the request this cycle
- dmem_rdata_i  input  XLEN  load data, valid when dmem_ack_i=1 for a load
- valid_o  output  1  writeback register holds a completed instruction
- rf_we_o  output  1  registered rf_we
- rf_waddr_o  output  RF_ADDR_W  registered RF destination
- rf_wdata_o  output  XLEN  load data if mem2rf, else ALU result

Behaviour:
- Reset values: the stage register valid is 0; FSM is IDLE.
- Reset values of outputs: valid_o=0, rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, dmem_req_o=0, stall_o=0.
- Stage register S:
  - Loads all inputs on a rising edge when stall_o=0.
  - Loads S.valid=0 when valid_i=0.
  - Holds all fields while stall_o=1.
- is_mem = S.valid & (S.mem_we | S.mem2rf). If both mem_we and mem2rf are set, the access is a store (dmem_we_o=1); S.mem2rf still selects load data for writeback.
- FSM:
  - IDLE: S is empty or holds a non-memory op.
  - REQ: is_mem=1 and the access is not yet acknowledged.
  - The state is a function of S and its transitions, not a free-running counter.
  - IDLE -> REQ when a memory op is captured.
  - REQ -> REQ while dmem_ack_i=0.
  - REQ -> IDLE on ack when no memory op is captured on the same edge.
  - REQ -> REQ on ack when a new memory op is captured on the same edge (back-to-back, no bubble).
- dmem_req_o = (state==REQ). dmem_addr_o=S.alu_result, dmem_wdata_o=S.mem_wdata, dmem_we_o=S.mem_we. All are stable while dmem_req_o=1.
- Zero-wait: ack may arrive in the first cycle of req; the access completes that cycle.
- stall_o = (state==REQ) & ~dmem_ack_i, combinational from ack.
- Writeback register update each edge:
  - Non-mem valid op in S -> valid_o=1, rf_wdata_o=S.alu_result. Latency is 1 cycle from capture.
  - Mem op -> written on the ack edge. valid_o=1; rf_wdata_o = S.mem2rf ? dmem_rdata_i : S.alu_result.
  - Otherwise (empty S, or waiting for ack) -> valid_o=0. rf_we_o, rf_waddr_o and rf_wdata_o hold their previous values.
- rf_we_o and rf_waddr_o pass S fields unchanged. Stores still report rf_we as received.
- dmem_ack_i while dmem_req_o=0 is ignored.
- Reset mid-access: the pending op is dropped, dmem_req_o=0 from the next cycle, and no writeback occurs. The memory is responsible for discarding the in-flight request.
- Total latency:
  - ALU op: 2 edges from execute output to valid_o.
  - Memory op: capture edge + N wait cycles + ack edge.

Optional Feature:
- Macro MEMORY_STAGE_FWD_EN.
- When defined, adds these outputs:
  - fwd_valid_o 1 = S.valid & S.rf_we & ~S.mem2rf
  - fwd_waddr_o RF_ADDR_W = S.rf_waddr
  - fwd_data_o XLEN = S.alu_result
- These outputs are combinational from S and are used for EX-operand forwarding.
- When not defined, the ports and logic are absent and the behaviour is otherwise identical.

Test Plan:
- Reset, then ALU op (valid_i=1, rf_we=1, waddr=5, alu=0x1234) -> 2 edges later valid_o=1, rf_waddr_o=5, rf_wdata_o=0x1234; dmem_req_o stays 0.
- Load from alu=0x100 with ack after 3 cycles, rdata=0xDEADBEEF:
  - dmem_req_o=1, dmem_we_o=0, addr=0x100 for 4 cycles.
  - stall_o=1 for 3 cycles.
  - valid_o=1, rf_wdata_o=0xDEADBEEF the edge after the ack cycle.
- Store (mem_we=1, wdata=0xA5A5A5A5, alu=0x200) with zero-wait ack:
  - dmem_req_o for 1 cycle, dmem_we_o=1, wdata=0xA5A5A5A5.
  - stall_o never 1.
- Back-to-back loads at 0x10 then 0x14, ack each after 1 wait cycle -> req stays high continuously, address switches 0x10 -> 0x14 on the first ack edge, and there are two valid_o pulses.
- rst asserted during a load wait -> next cycle dmem_req_o=0, valid_o=0, stall_o=0; a late ack is ignored.
- With MEMORY_STAGE_FWD_EN: ALU op waddr=7, alu=0x55 captured -> fwd_valid_o=1, fwd_waddr_o=7, fwd_data_o=0x55 in the same cycle; a load in S gives fwd_valid_o=0.
